// File: rtl/game_ctrl.sv
// game_ctrl: per-frame jump physics, obstacle scroll, game FSM and BCD scoring
// for the little-dinosaur game. Every output is a register.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE 00 | power-up wait, restart held high, waits for a start edge
// CLEAR   | one cycle, positions and score reloaded, restart high
// RUN  10 | physics and scroll advance on frame_tick, collide checked
// OVER 11 | frozen, game_over high, high score captured, waits for start
module game_ctrl #(
  parameter int GROUND_Y      = 475,
  parameter int BLOCK_START_X = 640,
  parameter int SPEED         = 4,
  parameter int JUMP_V0       = 16,
  parameter int GRAVITY       = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        jump_btn,
  input  logic        collide,
  output logic [9:0]  dinosaur_y,
  output logic [9:0]  block_x,
  output logic        restart,
  output logic        game_over,
  output logic [1:0]  state,
  output logic [15:0] score,
  output logic [15:0] hi_score
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_RUN   = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  localparam logic [9:0]        GROUND_C  = 10'(GROUND_Y);
  localparam logic [9:0]        BSTART_C  = 10'(BLOCK_START_X);
  localparam logic [9:0]        SPEED_C   = 10'(SPEED);
  localparam logic signed [6:0] JUMP_V0_C = 7'(JUMP_V0);
  localparam logic signed [6:0] GRAV_C    = 7'(GRAVITY);

  state_t             state_q, state_d;
  logic               start_q;
  logic               start_edge;
  logic signed [6:0]  vel_q, vel_d;
  logic               air_q, air_d;
  logic [9:0]         y_d, bx_d;
  logic [15:0]        score_d, hi_d;
  logic signed [10:0] y_next;

  // BCD +1 with per-digit carry; 9999 is sticky
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (v[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign start_edge = start_btn & ~start_q;
  assign y_next     = $signed({1'b0, dinosaur_y}) - $signed({{4{vel_q[6]}}, vel_q});
  assign state      = state_q;

  // Next-state and datapath: hold everything unless the current state says otherwise
  always_comb begin
    state_d = state_q;
    y_d     = dinosaur_y;
    bx_d    = block_x;
    vel_d   = vel_q;
    air_d   = air_q;
    score_d = score;
    hi_d    = hi_score;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (collide) begin
          state_d = ST_OVER;
        end else if (frame_tick) begin
          if (!air_q) begin
            if (jump_btn) begin
              air_d = 1'b1;
              vel_d = JUMP_V0_C;
            end
          end else if (y_next >= $signed({1'b0, GROUND_C})) begin
            y_d   = GROUND_C;
            vel_d = '0;
            air_d = 1'b0;
          end else begin
            y_d   = y_next[9:0];
            vel_d = vel_q - GRAV_C;
          end
          if (block_x < SPEED_C) begin
            bx_d    = BSTART_C;
            score_d = bcd_inc(score);
          end else begin
            bx_d = block_x - SPEED_C;
          end
        end
      end
      ST_OVER: begin
        // score is frozen here, so comparing every OVER cycle equals comparing on entry
        if (score > hi_score) hi_d = score;
        if (start_edge) state_d = ST_CLEAR;
      end
      default: state_d = ST_IDLE;
    endcase
    // reload on the way into CLEAR so the detector sees clean positions during restart
    if (state_d == ST_CLEAR) begin
      y_d     = GROUND_C;
      bx_d    = BSTART_C;
      vel_d   = '0;
      air_d   = 1'b0;
      score_d = '0;
    end
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      vel_q      <= '0;
      air_q      <= 1'b0;
      dinosaur_y <= GROUND_C;
      block_x    <= BSTART_C;
      score      <= '0;
      hi_score   <= '0;
      restart    <= 1'b1;
      game_over  <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_btn;
      vel_q      <= vel_d;
      air_q      <= air_d;
      dinosaur_y <= y_d;
      block_x    <= bx_d;
      score      <= score_d;
      hi_score   <= hi_d;
      restart    <= (state_d == ST_IDLE) || (state_d == ST_CLEAR);
      game_over  <= (state_d == ST_OVER);
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus pushes expected values, a monitor
// pops and compares them on the falling edge.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick, start_btn, jump_btn, collide;
  logic [9:0]  dinosaur_y, block_x;
  logic        restart, game_over;
  logic [1:0]  state;
  logic [15:0] score, hi_score;

  logic        f_tick, f_start;
  logic [9:0]  f_y, f_bx;
  logic        f_restart, f_over;
  logic [1:0]  f_state;
  logic [15:0] f_score, f_hi;

  game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn),
    .jump_btn(jump_btn), .collide(collide), .dinosaur_y(dinosaur_y),
    .block_x(block_x), .restart(restart), .game_over(game_over),
    .state(state), .score(score), .hi_score(hi_score)
  );

  // obstacle starts at 0, so every tick wraps and scores
  game_ctrl #(.BLOCK_START_X(0)) dut_fast (
    .clk(clk), .rst_n(rst_n), .frame_tick(f_tick), .start_btn(f_start),
    .jump_btn(1'b0), .collide(1'b0), .dinosaur_y(f_y),
    .block_x(f_bx), .restart(f_restart), .game_over(f_over),
    .state(f_state), .score(f_score), .hi_score(f_hi)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  int          m_y, m_vel, m_bx;
  bit          m_air;
  logic [15:0] m_score;

  task automatic push(input int sel, input logic [15:0] exp, input string name);
    chk_t c;
    c.sel  = sel;
    c.exp  = exp;
    c.name = name;
    sb_q.push_back(c);
  endtask

  function automatic logic [15:0] sample(input int sel);
    case (sel)
      0: return {14'd0, state};
      1: return {15'd0, restart};
      2: return {15'd0, game_over};
      3: return {6'd0, dinosaur_y};
      4: return {6'd0, block_x};
      5: return score;
      6: return hi_score;
      7: return f_score;
      8: return {6'd0, f_bx};
      default: return 16'hxxxx;
    endcase
  endfunction

  // decimal round-trip model of the saturating BCD counter
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    int d;
    d = v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
    d = (d >= 9999) ? 9999 : d + 1;
    return {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
  endfunction

  // monitor: compare everything queued since the last falling edge
  initial begin
    chk_t        c;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        c   = sb_q.pop_front();
        act = sample(c.sel);
        n_checks++;
        if (act !== c.exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic tick(input logic jmp, input bit chk);
    int yn;
    frame_tick = 1'b1;
    jump_btn   = jmp;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    jump_btn   = 1'b0;
    if (!m_air) begin
      if (jmp) begin
        m_air = 1'b1;
        m_vel = 16;
      end
    end else begin
      yn = m_y - m_vel;
      if (yn >= 475) begin
        m_y   = 475;
        m_vel = 0;
        m_air = 1'b0;
      end else begin
        m_y   = yn;
        m_vel = m_vel - 1;
      end
    end
    if (m_bx < 4) begin
      m_bx    = 640;
      m_score = bcd_inc(m_score);
    end else begin
      m_bx = m_bx - 4;
    end
    if (chk) begin
      push(3, 16'(m_y), "tick_y");
      push(4, 16'(m_bx), "tick_block_x");
      push(5, m_score, "tick_score");
    end
  endtask

  task automatic model_clear();
    m_y     = 475;
    m_vel   = 0;
    m_air   = 1'b0;
    m_bx    = 640;
    m_score = 16'h0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    frame_tick = 1'b0; start_btn = 1'b0; jump_btn = 1'b0; collide = 1'b0;
    f_tick = 1'b0; f_start = 1'b0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    push(0, 16'd0, "rst_state");
    push(1, 16'd1, "rst_restart");
    push(2, 16'd0, "rst_game_over");
    push(3, 16'd475, "rst_y");
    push(4, 16'd640, "rst_block_x");
    push(5, 16'h0000, "rst_score");
    push(6, 16'h0000, "rst_hi_score");
    rst_n = 1'b1;

    @(posedge clk); #1;
    start_btn = 1'b1;
    @(posedge clk); #1;
    push(0, 16'd1, "start_clear_state");
    push(1, 16'd1, "start_clear_restart");
    @(posedge clk); #1;
    push(0, 16'd2, "start_run_state");
    push(1, 16'd0, "start_run_restart");
    push(3, 16'd475, "start_run_y");
    push(4, 16'd640, "start_run_block_x");
    push(5, 16'h0000, "start_run_score");
    start_btn = 1'b0;

    // jump: launch tick then 33 airborne ticks
    tick(1'b1, 1'b1);
    push(3, 16'd475, "launch_y");
    for (int i = 1; i <= 33; i++) begin
      tick(1'b0, 1'b1);
      if (i == 1)  push(3, 16'd459, "jump_y1");
      if (i == 2)  push(3, 16'd444, "jump_y2");
      if (i == 16) push(3, 16'd339, "apex_y16");
      if (i == 17) push(3, 16'd339, "apex_y17");
      if (i == 32) push(3, 16'd459, "jump_y32");
      if (i == 33) push(3, 16'd475, "land_y33");
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    push(3, 16'd475, "grounded_after_land");

    // obstacle scroll to wrap (37 ticks done so far)
    for (int i = 37; i < 160; i++) tick(1'b0, 1'b0);
    push(4, 16'd0, "block_at_zero");
    push(5, 16'h0000, "score_before_wrap");
    tick(1'b0, 1'b1);
    push(4, 16'd640, "block_wrap");
    push(5, 16'h0001, "score_first_wrap");

    // run through 0099 -> 0100 carry
    guard = 0;
    while (m_score != 16'h0100 && guard < 20000) begin
      tick(1'b0, (m_bx < 4) ? 1'b1 : 1'b0);
      guard++;
    end
    push(5, 16'h0100, "score_carry_0100");

    for (int i = 0; i < 97; i++) tick(1'b0, 1'b0);
    push(4, 16'd252, "block_252");

    // collide together with frame_tick
    collide = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    collide = 1'b0;
    frame_tick = 1'b0;
    push(0, 16'd3, "over_state");
    push(2, 16'd1, "over_game_over");
    push(1, 16'd0, "over_restart");
    push(4, 16'd252, "over_block_frozen");
    push(5, 16'h0100, "over_score_frozen");
    push(6, 16'h0000, "hi_not_yet");
    @(posedge clk); #1;
    push(6, 16'h0100, "hi_captured");
    push(0, 16'd3, "over_holds");
    frame_tick = 1'b1;
    collide = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    frame_tick = 1'b0;
    collide = 1'b0;
    push(4, 16'd252, "over_ignores_tick");
    push(0, 16'd3, "over_ignores_collide");

    // restart with start held high
    start_btn = 1'b1;
    @(posedge clk); #1;
    push(0, 16'd1, "restart_clear_state");
    push(1, 16'd1, "restart_clear_restart");
    push(2, 16'd0, "restart_clear_game_over");
    @(posedge clk); #1;
    push(0, 16'd2, "restart_run_state");
    push(1, 16'd0, "restart_run_restart");
    push(5, 16'h0000, "restart_score");
    push(4, 16'd640, "restart_block_x");
    push(6, 16'h0100, "hi_retained");
    repeat (3) @(posedge clk);
    #1;
    push(0, 16'd2, "held_start_single");
    start_btn = 1'b0;
    @(posedge clk); #1;
    start_btn = 1'b1;
    @(posedge clk); #1;
    push(0, 16'd2, "run_ignores_start");
    push(1, 16'd0, "run_ignores_start_restart");
    start_btn = 1'b0;
    model_clear();

    // async reset mid-jump
    tick(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);
    n_checks++;
    if (dinosaur_y !== 10'd405) begin
      n_err++;
      $display("FAIL midjump_y: got %0d expected 405", dinosaur_y);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dinosaur_y !== 10'd475) begin
      n_err++;
      $display("FAIL async_rst_y_now: got %0d expected 475", dinosaur_y);
    end
    n_checks++;
    if (state !== 2'b00) begin
      n_err++;
      $display("FAIL async_rst_state_now: got %b expected 00", state);
    end
    n_checks++;
    if (hi_score !== 16'h0000) begin
      n_err++;
      $display("FAIL async_rst_hi_now: got %h expected 0000", hi_score);
    end
    push(3, 16'd475, "async_rst_y");
    push(0, 16'd0, "async_rst_state");
    push(6, 16'h0000, "async_rst_hi");
    push(4, 16'd640, "async_rst_block_x");
    push(5, 16'h0000, "async_rst_score");
    push(1, 16'd1, "async_rst_restart");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // saturation on the always-wrapping instance
    @(posedge clk); #1;
    f_start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    push(7, 16'h0000, "fast_score_start");
    f_tick = 1'b1;
    for (int i = 1; i <= 10003; i++) begin
      @(posedge clk); #1;
      if (i == 10)    push(7, 16'h0010, "fast_score_10");
      if (i == 100)   push(7, 16'h0100, "fast_score_100");
      if (i == 9998)  push(7, 16'h9998, "fast_score_9998");
      if (i == 9999)  push(7, 16'h9999, "fast_score_9999");
      if (i == 10003) push(7, 16'h9999, "fast_score_saturated");
    end
    f_tick = 1'b0;
    push(8, 16'd0, "fast_block_x");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
